// File: rtl/mult_sequencer_if.sv
// Operand, adder and result signals of the sequential 8x8 signed multiplier.
// The master drives the operand controls and the adder sum; the slave is the sequencer.
interface mult_sequencer_if;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] SW;
    logic [8:0] add_a;
    logic [8:0] add_b;
    logic       add_sub;
    logic [8:0] add_sum;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Done;
    logic       Busy;

    modport master (
        output Run, ClearA_LoadB, SW, add_sum,
        input  add_a, add_b, add_sub, Aval, Bval, Xval, Done, Busy
    );

    modport slave (
        input  Run, ClearA_LoadB, SW, add_sum,
        output add_a, add_b, add_sub, Aval, Bval, Xval, Done, Busy
    );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-add signed 8x8 multiplier sequencer driving an external 9-bit adder.
// The final partial product is subtracted, so {A,B} ends as the signed product S x B.
module mult_sequencer (
    input  logic            Clk,
    input  logic            Reset_n,
    mult_sequencer_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              x_q, x_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              add_sub_q, add_sub_d;

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            x_q       <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            add_sub_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            add_sub_q <= add_sub_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ClearA_LoadB) begin
                    b_d = bus.SW;
                    a_d = '0;
                    x_d = 1'b0;
                end else if (bus.Run) begin
                    s_d     = bus.SW;
                    a_d     = '0;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (b_q[0]) begin
                    x_d = bus.add_sum[DATA_W];
                    a_d = bus.add_sum[DATA_W-1:0];
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                a_d = {x_q, a_q[DATA_W-1:1]};
                b_d = {a_q[0], b_q[DATA_W-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_ADD;
                end
            end
            ST_HOLD: begin
                if (!bus.Run) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags are registered from the state being entered
        done_d    = (state_d == ST_HOLD);
        busy_d    = (state_d == ST_ADD) || (state_d == ST_SHIFT);
        add_sub_d = (state_d == ST_ADD) && (cnt_d == CNT_LAST);
    end

    assign bus.add_a   = {a_q[DATA_W-1], a_q};
    assign bus.add_b   = {s_q[DATA_W-1], s_q};
    assign bus.add_sub = add_sub_q;
    assign bus.Aval    = a_q;
    assign bus.Bval    = b_q;
    assign bus.Xval    = x_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = busy_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed-vector bench for mult_sequencer with a behavioural 9-bit add/subtract adder.
module tb_mult_sequencer;
    logic Clk;
    logic Reset_n;
    int   n_checks;
    int   n_fail;

    mult_sequencer_if bus ();

    mult_sequencer dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // External adder: subtract inverts add_b and injects carry-in
    assign bus.add_sum = bus.add_a + (bus.add_sub ? ~bus.add_b : bus.add_b) + 9'(bus.add_sub);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] v);
        @(negedge Clk);
        bus.ClearA_LoadB = 1'b1;
        bus.SW           = v;
        @(negedge Clk);
        bus.ClearA_LoadB = 1'b0;
    endtask

    // Start a multiply, check timing and result, hold Run for extra cycles, then release
    task automatic run_check(input string tag, input logic [7:0] s,
                             input logic [7:0] exp_a, input logic [7:0] exp_b,
                             input logic exp_x, input int hold_extra, input bit disturb);
        int busy_n, as_n, as_cyc, done_n;
        busy_n = 0; as_n = 0; as_cyc = 0; done_n = 0;
        @(negedge Clk);
        bus.SW  = s;
        bus.Run = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge Clk);
            if (bus.Busy) busy_n++;
            if (bus.add_sub) begin
                as_n++;
                as_cyc = cyc;
            end
            if (cyc == 16) check_eq({tag, " done_early"}, 16'(bus.Done), 16'd0);
            if (disturb) begin
                bus.SW           = 8'($urandom);
                bus.ClearA_LoadB = cyc[0];
            end
        end
        @(negedge Clk);
        bus.ClearA_LoadB = 1'b0;
        check_eq({tag, " busy_cycles"}, 16'(busy_n), 16'd16);
        check_eq({tag, " add_sub_count"}, 16'(as_n), 16'd1);
        check_eq({tag, " add_sub_cycle"}, 16'(as_cyc), 16'd15);
        check_eq({tag, " done"}, 16'(bus.Done), 16'd1);
        check_eq({tag, " busy_in_hold"}, 16'(bus.Busy), 16'd0);
        check_eq({tag, " product"}, {bus.Aval, bus.Bval}, {exp_a, exp_b});
        check_eq({tag, " xval"}, 16'(bus.Xval), 16'(exp_x));
        for (int h = 0; h < hold_extra; h++) begin
            @(negedge Clk);
            if (bus.Done && !bus.Busy && {bus.Aval, bus.Bval} == {exp_a, exp_b}) done_n++;
        end
        check_eq({tag, " hold_cycles"}, 16'(done_n), 16'(hold_extra));
        bus.Run = 1'b0;
        @(negedge Clk);
        check_eq({tag, " idle_done"}, 16'(bus.Done), 16'd0);
        check_eq({tag, " idle_result_kept"}, {bus.Aval, bus.Bval}, {exp_a, exp_b});
        @(negedge Clk);
        check_eq({tag, " idle_busy"}, 16'(bus.Busy), 16'd0);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        Reset_n          = 1'b0;
        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        bus.SW           = 8'h00;
        repeat (2) @(negedge Clk);
        check_eq("reset product", {bus.Aval, bus.Bval}, 16'h0000);
        check_eq("reset flags", {12'd0, bus.Xval, bus.Done, bus.Busy, bus.add_sub}, 16'h0000);
        Reset_n = 1'b1;

        // -7 x 3 = -21
        load_b(8'h03);
        check_eq("load bval", 16'(bus.Bval), 16'h0003);
        run_check("m7x3", 8'hF9, 8'hFF, 8'hEB, 1'b1, 0, 1'b0);

        // ClearA_LoadB wins over Run; A had 0xFF from the previous product
        @(negedge Clk);
        bus.SW = 8'h2A; bus.ClearA_LoadB = 1'b1; bus.Run = 1'b1;
        @(negedge Clk);
        bus.ClearA_LoadB = 1'b0; bus.Run = 1'b0;
        check_eq("both bval", 16'(bus.Bval), 16'h002A);
        check_eq("both aval_x", {bus.Aval, 7'd0, bus.Xval}, 16'h0000);
        check_eq("both busy", 16'(bus.Busy), 16'd0);
        @(negedge Clk);
        check_eq("both busy_later", 16'(bus.Busy), 16'd0);

        // -128 x -128 = +16384
        load_b(8'h80);
        run_check("m128x128", 8'h80, 8'h40, 8'h00, 1'b0, 0, 1'b0);

        // 127 x -128 = -16256
        load_b(8'h80);
        run_check("p127xm128", 8'h7F, 8'hC0, 8'h80, 1'b1, 0, 1'b0);

        // Run held for 40 cycles with SW/ClearA_LoadB disturbed: -5 x 12 = -60
        load_b(8'h0C);
        run_check("held", 8'hFB, 8'hFF, 8'hC4, 1'b1, 23, 1'b1);

        // Reset in cycle 7 of a run aborts it
        load_b(8'h09);
        @(negedge Clk);
        bus.SW  = 8'h33;
        bus.Run = 1'b1;
        repeat (6) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_eq("abort product", {bus.Aval, bus.Bval}, 16'h0000);
        check_eq("abort flags", {bus.add_a[7:0], 4'd0, bus.Xval, bus.Done, bus.Busy, bus.add_sub}, 16'h0000);
        bus.Run = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check_eq("abort idle_busy", 16'(bus.Busy), 16'd0);
        load_b(8'h05);
        run_check("p5x5", 8'h05, 8'h00, 8'h19, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
